// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode encodings and width default for the 8-bit ALU
package alu_pkg;

  localparam int DEFAULT_WIDTH = 8;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;

  // Only ADD and SUB can raise carry/borrow; every other opcode forces it low.
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_8bit_if.sv
// rtl/alu_8bit_if.sv - operand/opcode inputs and registered flag outputs of the ALU
interface alu_8bit_if import alu_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       opcode;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             zero;

  modport master (
    output a,
    output b,
    output opcode,
    input  result,
    input  carry_out,
    input  zero
  );

  modport slave (
    input  a,
    input  b,
    input  opcode,
    output result,
    output carry_out,
    output zero
  );

endinterface

// File: rtl/alu_8bit_datapath.sv
// rtl/alu_8bit_datapath.sv - combinational operation select producing next result and flags
module alu_8bit_datapath import alu_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       opcode,
  output logic [WIDTH-1:0] res_next,
  output logic             carry_next,
  output logic             zero_next
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           carry_raw;

  // Top bit of the widened difference is the borrow, i.e. set exactly when a < b.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    res_next  = '0;
    carry_raw = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_next  = sum[WIDTH-1:0];
        carry_raw = sum[WIDTH];
      end
      OP_SUB: begin
        res_next  = diff[WIDTH-1:0];
        carry_raw = diff[WIDTH];
      end
      OP_AND: res_next = a & b;
      OP_OR:  res_next = a | b;
      OP_XOR: res_next = a ^ b;
      OP_NOT: res_next = ~a;
      default: begin
        res_next  = '0;
        carry_raw = 1'b0;
      end
    endcase
  end

  assign carry_next = carry_raw & is_arith(opcode);
  assign zero_next  = (res_next == '0);

endmodule

// File: rtl/alu_8bit.sv
// rtl/alu_8bit.sv - registered ALU top: datapath plus async-reset output register
module alu_8bit import alu_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  alu_8bit_if.slave  bus
);

  logic [WIDTH-1:0] res_next;
  logic             carry_next;
  logic             zero_next;

  logic [WIDTH-1:0] result_d, result_q;
  logic             carry_d,  carry_q;
  logic             zero_d,   zero_q;

  alu_8bit_datapath #(.WIDTH(WIDTH)) u_datapath (
    .a          (bus.a),
    .b          (bus.b),
    .opcode     (bus.opcode),
    .res_next   (res_next),
    .carry_next (carry_next),
    .zero_next  (zero_next)
  );

  always_comb begin
    result_d = res_next;
    carry_d  = carry_next;
    zero_d   = zero_next;
  end

  // Zero resets high so it agrees with the cleared result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b1;
    end else begin
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_alu_8bit.sv
// tb/tb_alu_8bit.sv - vector table, reset sequences and model-checked sweeps for alu_8bit
module tb_alu_8bit;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_miss;

  alu_8bit_if #(.WIDTH(8)) bus ();

  alu_8bit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic       c;
    logic       z;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string nm, input logic [7:0] er, input logic ec, input logic ez);
    n_vec++;
    if (bus.result !== er || bus.carry_out !== ec || bus.zero !== ez) begin
      n_miss++;
      $display("FAIL %s: got result=%02h carry=%b zero=%b, expected result=%02h carry=%b zero=%b",
               nm, bus.result, bus.carry_out, bus.zero, er, ec, ez);
    end
  endtask

  function automatic void model(input int a, input int b, input int op,
                                output logic [7:0] r, output logic c, output logic z);
    int rv;
    int cv;
    rv = 0;
    cv = 0;
    case (op)
      0: begin rv = a + b; cv = (rv > 255) ? 1 : 0; rv = rv % 256; end
      1: begin cv = (a < b) ? 1 : 0; rv = (a - b + 256) % 256; end
      2: rv = a & b;
      3: rv = a | b;
      4: rv = a ^ b;
      5: rv = 255 - a;
      default: rv = 0;
    endcase
    r = rv[7:0];
    c = (cv != 0);
    z = (rv == 0);
  endfunction

  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    bus.a      = a;
    bus.b      = b;
    bus.opcode = op;
  endtask

  initial begin
    logic [7:0] er;
    logic       ec;
    logic       ez;
    logic [7:0] pr;
    logic       pc;
    logic       pz;
    logic       have_prev;
    logic [7:0] bsel [8];
    n_vec  = 0;
    n_miss = 0;

    vecs.push_back('{"add_ff_01", 8'hFF, 8'h01, 3'b000, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{"add_ff_ff", 8'hFF, 8'hFF, 3'b000, 8'hFE, 1'b1, 1'b0});
    vecs.push_back('{"add_80_80", 8'h80, 8'h80, 3'b000, 8'h00, 1'b1, 1'b1});
    vecs.push_back('{"add_01_01", 8'h01, 8'h01, 3'b000, 8'h02, 1'b0, 1'b0});
    vecs.push_back('{"sub_00_01", 8'h00, 8'h01, 3'b001, 8'hFF, 1'b1, 1'b0});
    vecs.push_back('{"sub_ff_ff", 8'hFF, 8'hFF, 3'b001, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{"sub_01_ff", 8'h01, 8'hFF, 3'b001, 8'h02, 1'b1, 1'b0});
    vecs.push_back('{"sub_80_01", 8'h80, 8'h01, 3'b001, 8'h7F, 1'b0, 1'b0});
    vecs.push_back('{"and_aa_55", 8'hAA, 8'h55, 3'b010, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{"or_aa_55",  8'hAA, 8'h55, 3'b011, 8'hFF, 1'b0, 1'b0});
    vecs.push_back('{"xor_ff_ff", 8'hFF, 8'hFF, 3'b100, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{"not_a5",    8'hA5, 8'h3C, 3'b101, 8'h5A, 1'b0, 1'b0});
    vecs.push_back('{"not_ff",    8'hFF, 8'h12, 3'b101, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{"rsv_110",   8'hAB, 8'hCD, 3'b110, 8'h00, 1'b0, 1'b1});
    vecs.push_back('{"rsv_111",   8'hAB, 8'hCD, 3'b111, 8'h00, 1'b0, 1'b1});

    // Reset held with nonzero inputs: outputs forced before and after clocking.
    rst = 1'b1;
    drive(8'hFF, 8'hFF, 3'b000);
    #1;
    check("reset_async", 8'h00, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_held", 8'h00, 1'b0, 1'b1);
    rst = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].op);
      @(negedge clk);
      check(vecs[i].name, vecs[i].res, vecs[i].c, vecs[i].z);
    end

    // Mid-stream reset clears outputs before the next edge; first edge after release is normal.
    drive(8'hFF, 8'hFF, 3'b000);
    @(posedge clk);
    #1;
    check("pre_midreset", 8'hFE, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("midreset_async", 8'h00, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    drive(8'h01, 8'h01, 3'b000);
    @(posedge clk);
    #1;
    check("first_after_reset", 8'h02, 1'b0, 1'b0);

    // Back-to-back sweep: every opcode, every a, selected b values.
    have_prev = 1'b0;
    pr = '0; pc = 1'b0; pz = 1'b0;
    bsel = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF, 8'hA5, 8'h55, 8'h00};
    for (int op = 0; op < 6; op++) begin
      for (int a = 0; a < 256; a++) begin
        bsel[7] = a[7:0];
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          if (have_prev) check("sweep", pr, pc, pz);
          drive(a[7:0], bsel[k], op[2:0]);
          model(a, int'(bsel[k]), op, pr, pc, pz);
          have_prev = 1'b1;
        end
      end
    end
    @(negedge clk);
    check("sweep_last", pr, pc, pz);

    // Random back-to-back traffic including reserved opcodes.
    have_prev = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [2:0] ro;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      ro = 3'($urandom_range(0, 7));
      @(negedge clk);
      if (have_prev) check("random", pr, pc, pz);
      drive(ra, rb, ro);
      model(int'(ra), int'(rb), int'(ro), er, ec, ez);
      pr = er; pc = ec; pz = ez;
      have_prev = 1'b1;
    end
    @(negedge clk);
    check("random_last", pr, pc, pz);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
